// File: rtl/cursor_pkg.sv
// Shared types and the saturating step helper for the cursor stepper.
package cursor_pkg;

  // Auto-repeat controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Per-axis movement: -1, 0 or +1.
  typedef logic signed [1:0] delta_t;

  localparam delta_t DELTA_POS  = 2'sb01;
  localparam delta_t DELTA_NEG  = 2'sb11;
  localparam delta_t DELTA_ZERO = 2'sb00;

  // Working width of sat_step; callers widen their coordinate into it.
  localparam int SAT_W = 16;

  // Move value by delta, clamped to [0, max]; never wraps.
  function automatic logic [SAT_W-1:0] sat_step(
    input logic [SAT_W-1:0] value,
    input delta_t           delta,
    input logic [SAT_W-1:0] max
  );
    logic [SAT_W-1:0] r;
    r = value;
    if (delta == DELTA_POS) begin
      if (value < max) r = value + 1'b1;
      else             r = max;
    end else if (delta == DELTA_NEG) begin
      if (value != '0) r = value - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a tick-counted debouncer for one raw button.
module button_debouncer #(
  parameter int DB_TICKS = 4,
  parameter int CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam logic [CW-1:0] DB_LAST = CW'(DB_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next debounce state: count ticks while the synced level disagrees, flip on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == DB_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/cursor_stepper.sv
// Turns four direction buttons into a saturating (x, y) cursor with press-and-hold auto-repeat.
module cursor_stepper
  import cursor_pkg::*;
#(
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int DB_TICKS     = 4,
  parameter int HOLD_TICKS   = 16,
  parameter int REPEAT_TICKS = 4,
  parameter int CW           = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           moved
);

  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_TICKS);
  localparam logic [CW-1:0] TIMER_LAST  = CW'(1);

  logic up_lvl, down_lvl, left_lvl, right_lvl;

  button_debouncer #(.DB_TICKS(DB_TICKS), .CW(CW)) u_db_up (
    .clk(clk), .rst(rst), .tick(tick), .raw(btn_up), .level(up_lvl)
  );
  button_debouncer #(.DB_TICKS(DB_TICKS), .CW(CW)) u_db_down (
    .clk(clk), .rst(rst), .tick(tick), .raw(btn_down), .level(down_lvl)
  );
  button_debouncer #(.DB_TICKS(DB_TICKS), .CW(CW)) u_db_left (
    .clk(clk), .rst(rst), .tick(tick), .raw(btn_left), .level(left_lvl)
  );
  button_debouncer #(.DB_TICKS(DB_TICKS), .CW(CW)) u_db_right (
    .clk(clk), .rst(rst), .tick(tick), .raw(btn_right), .level(right_lvl)
  );

  delta_t         dx, dy;
  logic           active;
  state_t         state_q;
  logic [CW-1:0]  timer_q;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           moved_q, moved_d;

  // Direction decode: opposing buttons cancel each other out.
  always_comb begin
    dx = DELTA_ZERO;
    dy = DELTA_ZERO;
    if (right_lvl && !left_lvl)      dx = DELTA_POS;
    else if (left_lvl && !right_lvl) dx = DELTA_NEG;
    if (down_lvl && !up_lvl)         dy = DELTA_POS;
    else if (up_lvl && !down_lvl)    dy = DELTA_NEG;
    active = (dx != DELTA_ZERO) || (dy != DELTA_ZERO);
  end

  // Candidate position for a step; each axis saturates on its own.
  always_comb begin
    x_d     = X_W'(sat_step(SAT_W'(x_q), dx, SAT_W'(X_MAX)));
    y_d     = Y_W'(sat_step(SAT_W'(y_q), dy, SAT_W'(Y_MAX)));
    moved_d = (x_d != x_q) || (y_d != y_q);
  end

  // Auto-repeat FSM; position and moved strobe are registered together so moved aligns with x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      x_q     <= X_W'(X_INIT);
      y_q     <= Y_W'(Y_INIT);
      moved_q <= 1'b0;
    end else begin
      moved_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (active) begin
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= moved_d;
            timer_q <= HOLD_LOAD;
            state_q <= DELAY;
          end
        end
        DELAY: begin
          if (!active) begin
            state_q <= IDLE;
          end else if (tick) begin
            if (timer_q == TIMER_LAST) begin
              x_q     <= x_d;
              y_q     <= y_d;
              moved_q <= moved_d;
              timer_q <= REPEAT_LOAD;
              state_q <= REPEAT;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!active) begin
            state_q <= IDLE;
          end else if (tick) begin
            if (timer_q == TIMER_LAST) begin
              x_q     <= x_d;
              y_q     <= y_d;
              moved_q <= moved_d;
              timer_q <= REPEAT_LOAD;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign moved = moved_q;

endmodule

// File: tb/tb_cursor_stepper.sv
// Directed bench for cursor_stepper: reset, single press, bounce, auto-repeat, saturation, reset mid-repeat.
module tb_cursor_stepper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [9:0] x;
  logic [8:0] y;
  logic       moved;

  int errs = 0;
  int checks = 0;
  int tick_period = 4;
  int tick_cnt = 0;
  int mv_total = 0;
  int mv_tk[$];
  int mv_y[$];
  bit dbl = 1'b0;
  logic moved_prev = 1'b0;

  always #5 clk = ~clk;

  cursor_stepper #(
    .X_W(10), .Y_W(9), .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240),
    .DB_TICKS(4), .HOLD_TICKS(16), .REPEAT_TICKS(4), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x(x), .y(y), .moved(moved)
  );

  // tick: one clock high every tick_period clocks (constantly high when period is 1)
  initial begin
    forever begin
      if (tick_period <= 1) begin
        @(posedge clk); #1 tick = 1'b1;
      end else begin
        for (int i = 0; i < tick_period - 1; i++) begin
          @(posedge clk); #1 tick = 1'b0;
        end
        @(posedge clk); #1 tick = 1'b1;
      end
    end
  end

  always @(posedge clk) if (!rst && tick) tick_cnt <= tick_cnt + 1;

  always @(negedge clk) begin
    if (moved) begin
      mv_total = mv_total + 1;
      mv_tk.push_back(tick_cnt);
      mv_y.push_back(int'(y));
      if (moved_prev) dbl = 1'b1;
    end
    moved_prev = moved;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick && !rst) k++;
    end
    #1;
  endtask

  task automatic wait_move(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (moved) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (x !== 10'd320) begin errs++; $display("FAIL reset_x: got %0d expected 320", x); end
    checks++; if (y !== 9'd240) begin errs++; $display("FAIL reset_y: got %0d expected 240", y); end
    checks++; if (moved !== 1'b0) begin errs++; $display("FAIL reset_moved: got %b expected 0", moved); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single_press();
    int base;
    bit ok;
    tick_period = 4;
    wait_ticks(1);
    base = mv_total;
    btn_right = 1'b1;
    wait_move(200, ok);
    checks++; if (!ok) begin errs++; $display("FAIL press_seen: got no moved expected a pulse"); end
    checks++; if (x !== 10'd321) begin errs++; $display("FAIL press_x: got %0d expected 321", x); end
    checks++; if (y !== 9'd240) begin errs++; $display("FAIL press_y: got %0d expected 240", y); end
    wait_ticks(5);
    btn_right = 1'b0;
    wait_ticks(10);
    checks++; if (mv_total - base != 1) begin errs++; $display("FAIL press_count: got %0d expected 1", mv_total - base); end
    checks++; if (x !== 10'd321) begin errs++; $display("FAIL press_final_x: got %0d expected 321", x); end
  endtask

  task automatic test_bounce();
    int base;
    base = mv_total;
    for (int i = 0; i < 10; i++) begin
      btn_left = ~btn_left;
      wait_ticks(2);
    end
    btn_left = 1'b0;
    wait_ticks(8);
    checks++; if (mv_total != base) begin errs++; $display("FAIL bounce_moves: got %0d expected 0", mv_total - base); end
    checks++; if (x !== 10'd321) begin errs++; $display("FAIL bounce_x: got %0d expected 321", x); end
    checks++; if (y !== 9'd240) begin errs++; $display("FAIL bounce_y: got %0d expected 240", y); end
  endtask

  task automatic test_auto_repeat();
    int base, n;
    bit ok;
    int exp_d[4] = '{16, 4, 4, 4};
    base = mv_total;
    btn_down = 1'b1;
    wait_move(200, ok);
    checks++; if (!ok) begin errs++; $display("FAIL repeat_first: got no moved expected a pulse"); end
    wait_ticks(26);
    btn_down = 1'b0;
    wait_ticks(20);
    n = mv_total - base;
    checks++; if (n != 5) begin errs++; $display("FAIL repeat_count: got %0d expected 5", n); end
    if (n >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (mv_y[base + i] != 241 + i) begin
          errs++; $display("FAIL repeat_y%0d: got %0d expected %0d", i, mv_y[base + i], 241 + i);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mv_tk[base + i + 1] - mv_tk[base + i] != exp_d[i]) begin
          errs++; $display("FAIL repeat_gap%0d: got %0d ticks expected %0d", i,
                           mv_tk[base + i + 1] - mv_tk[base + i], exp_d[i]);
        end
      end
    end
    checks++; if (y !== 9'd245) begin errs++; $display("FAIL repeat_final_y: got %0d expected 245", y); end
    checks++; if (dbl !== 1'b0) begin errs++; $display("FAIL repeat_double: got back-to-back moved expected none"); end
  endtask

  task automatic test_saturation();
    int base;
    bit ok;
    tick_period = 1;
    btn_left = 1'b1;
    for (int i = 0; i < 3000 && x != 10'd0; i++) @(negedge clk);
    checks++; if (x !== 10'd0) begin errs++; $display("FAIL sat_reach_x: got %0d expected 0", x); end
    #1;
    base = mv_total;
    wait_ticks(20);
    checks++; if (mv_total != base) begin errs++; $display("FAIL sat_left_moves: got %0d expected 0", mv_total - base); end
    checks++; if (x !== 10'd0) begin errs++; $display("FAIL sat_left_x: got %0d expected 0", x); end
    checks++; if (y !== 9'd245) begin errs++; $display("FAIL sat_left_y: got %0d expected 245", y); end
    btn_left = 1'b0;
    wait_ticks(12);
    // both horizontal buttons cancel
    base = mv_total;
    btn_left = 1'b1; btn_right = 1'b1;
    wait_ticks(30);
    checks++; if (mv_total != base) begin errs++; $display("FAIL conflict_moves: got %0d expected 0", mv_total - base); end
    checks++; if (x !== 10'd0) begin errs++; $display("FAIL conflict_x: got %0d expected 0", x); end
    btn_left = 1'b0; btn_right = 1'b0;
    wait_ticks(12);
    // walk y down to 5: fast hold, then single taps
    btn_up = 1'b1;
    for (int i = 0; i < 3000 && y > 9'd10; i++) @(negedge clk);
    #1 btn_up = 1'b0;
    wait_ticks(12);
    for (int i = 0; i < 12 && y > 9'd5; i++) begin
      btn_up = 1'b1;
      wait_ticks(8);
      btn_up = 1'b0;
      wait_ticks(12);
    end
    checks++; if (y !== 9'd5) begin errs++; $display("FAIL walk_y: got %0d expected 5", y); end
    // diagonal at the left edge: y still moves
    btn_up = 1'b1; btn_left = 1'b1;
    wait_move(50, ok);
    checks++; if (!ok) begin errs++; $display("FAIL diag_seen: got no moved expected a pulse"); end
    checks++; if (y !== 9'd4) begin errs++; $display("FAIL diag_y: got %0d expected 4", y); end
    checks++; if (x !== 10'd0) begin errs++; $display("FAIL diag_x: got %0d expected 0", x); end
  endtask

  task automatic test_reset_mid_repeat();
    int base, tk0;
    bit ok;
    tick_period = 4;
    wait_move(200, ok);
    checks++; if (!ok || y !== 9'd3) begin errs++; $display("FAIL mid_second_step: got y=%0d expected 3", y); end
    #2 rst = 1'b1;
    #1;
    checks++; if (x !== 10'd320 || y !== 9'd240 || moved !== 1'b0) begin
      errs++; $display("FAIL mid_reset_async: got x=%0d y=%0d moved=%b expected 320 240 0", x, y, moved);
    end
    btn_left = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (x !== 10'd320 || y !== 9'd240 || moved !== 1'b0) begin
      errs++; $display("FAIL mid_reset_hold: got x=%0d y=%0d moved=%b expected 320 240 0", x, y, moved);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (tick) break;
    end
    @(negedge clk);
    rst = 1'b0;
    tk0 = tick_cnt;
    base = mv_total;
    wait_ticks(3);
    checks++; if (mv_total != base || y !== 9'd240) begin
      errs++; $display("FAIL mid_early_step: got %0d moves y=%0d expected 0 moves y=240", mv_total - base, y);
    end
    wait_move(100, ok);
    checks++; if (!ok || y !== 9'd239 || x !== 10'd320) begin
      errs++; $display("FAIL mid_resume: got x=%0d y=%0d expected 320 239", x, y);
    end
    #1;
    checks++; if (mv_total - base != 1 || mv_tk[mv_tk.size() - 1] - tk0 != 4) begin
      errs++; $display("FAIL mid_resume_ticks: got %0d ticks expected 4", mv_tk[mv_tk.size() - 1] - tk0);
    end
    btn_up = 1'b0;
    wait_ticks(10);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_saturation();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
